// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing checker: recovers sync geometry from the pixel stream,
// CRCs the active area of each frame and tracks lock against the nominal timing.
module vga_timing_monitor #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pix_en_i,
  input  logic [3:0]  vga_r_i,
  input  logic [3:0]  vga_g_i,
  input  logic [3:0]  vga_b_i,
  input  logic        vga_hs_i,
  input  logic        vga_vs_i,
  output logic        locked_o,
  output logic        frame_done_o,
  output logic [15:0] frame_crc_o,
  output logic [11:0] line_len_o,
  output logic [10:0] frame_lines_o,
  output logic        h_err_o,
  output logic        v_err_o,
  output logic [15:0] frame_cnt_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic        Pol    = (SYNC_POL != 0);
  localparam logic [11:0] HTot   = 12'(H_TOTAL);
  localparam logic [11:0] HSyncW = 12'(H_SYNC);
  localparam logic [11:0] HActLo = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] HActHi = 12'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [10:0] VTot   = 11'(V_TOTAL);
  localparam logic [10:0] VSyncW = 11'(V_SYNC);
  localparam logic [10:0] VActLo = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] VActHi = 11'(V_SYNC + V_BACK + V_ACTIVE);

  typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

  state_e      state_q, state_d;
  logic        hs_q, vs_q;
  logic        vpend_q, vpend_d;
  logic        ferr_q, ferr_d;
  logic [11:0] hcnt_q, hcnt_d, hcnt_inc;
  logic [10:0] vcnt_q, vcnt_d, vcnt_inc;
  logic [15:0] crc_q, crc_d;
  logic        locked_q, locked_d, done_q, done_d, herr_q, herr_d, verr_q, verr_d;
  logic [15:0] fcrc_q, fcrc_d, fcnt_q, fcnt_d;
  logic [11:0] llen_q, llen_d;
  logic [10:0] flines_q, flines_d;
  logic        hs_edge, hs_fall, vs_edge, vs_fall, pix_act, check_en;

  // Unrolled CRC-16-CCITT over one 12-bit pixel, MSB first.
  function automatic logic [15:0] crc12(input logic [15:0] crc, input logic [11:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 11; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Edges compare the incoming strobed sample against the previous strobed level.
  assign hs_edge = pix_en_i & (vga_hs_i == Pol) & (hs_q != Pol);
  assign hs_fall = pix_en_i & (vga_hs_i != Pol) & (hs_q == Pol);
  assign vs_edge = pix_en_i & (vga_vs_i == Pol) & (vs_q != Pol);
  assign vs_fall = pix_en_i & (vga_vs_i != Pol) & (vs_q == Pol);

  assign hcnt_inc = (&hcnt_q) ? hcnt_q : hcnt_q + 12'd1;
  assign vcnt_inc = (&vcnt_q) ? vcnt_q : vcnt_q + 11'd1;

  always_comb begin
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    vpend_d = vpend_q;
    if (pix_en_i) hcnt_d = hs_edge ? 12'd0 : hcnt_inc;
    if (vs_edge) vpend_d = 1'b1;
    if (hs_edge) begin
      if (vs_edge || vpend_q) begin
        vcnt_d  = 11'd0;
        vpend_d = 1'b0;
      end else begin
        vcnt_d = vcnt_inc;
      end
    end
  end

  assign pix_act  = pix_en_i && (hcnt_d >= HActLo) && (hcnt_d < HActHi) &&
                    (vcnt_d >= VActLo) && (vcnt_d < VActHi);
  assign check_en = (state_q != StSearch);
  assign herr_d   = check_en & ((hs_edge & (hcnt_inc != HTot)) | (hs_fall & (hcnt_inc != HSyncW)));
  assign verr_d   = check_en & ((vs_edge & (vcnt_inc != VTot)) | (vs_fall & (vcnt_d != VSyncW)));

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    ferr_d   = ferr_q | herr_d | verr_d;
    done_d   = 1'b0;
    fcrc_d   = fcrc_q;
    flines_d = flines_q;
    fcnt_d   = fcnt_q;
    llen_d   = hs_edge ? hcnt_inc : llen_q;
    if (pix_act) crc_d = crc12(crc_q, {vga_r_i, vga_g_i, vga_b_i});
    case (state_q)
      StSearch:  if (vs_edge) state_d = StMeasure;
      StMeasure: if (vs_edge && !ferr_q && !herr_d && !verr_d) state_d = StLocked;
      StLocked: begin
        if (herr_d || verr_d) begin
          state_d = StMeasure;
          fcnt_d  = 16'd0;
        end else if (vs_edge) begin
          fcnt_d = fcnt_q + 16'd1;
        end
      end
      default: state_d = StSearch;
    endcase
    // The closing vsync edge also opens the next frame.
    if (vs_edge) begin
      if (state_q != StSearch) begin
        done_d   = 1'b1;
        fcrc_d   = crc_q;
        flines_d = vcnt_inc;
      end
      crc_d  = 16'hFFFF;
      ferr_d = 1'b0;
    end
    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StSearch;
      hs_q     <= ~Pol;
      vs_q     <= ~Pol;
      vpend_q  <= 1'b0;
      ferr_q   <= 1'b0;
      hcnt_q   <= 12'd0;
      vcnt_q   <= 11'd0;
      crc_q    <= 16'hFFFF;
      locked_q <= 1'b0;
      done_q   <= 1'b0;
      herr_q   <= 1'b0;
      verr_q   <= 1'b0;
      fcrc_q   <= 16'd0;
      fcnt_q   <= 16'd0;
      llen_q   <= 12'd0;
      flines_q <= 11'd0;
    end else begin
      state_q  <= state_d;
      if (pix_en_i) begin
        hs_q <= vga_hs_i;
        vs_q <= vga_vs_i;
      end
      vpend_q  <= vpend_d;
      ferr_q   <= ferr_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      crc_q    <= crc_d;
      locked_q <= locked_d;
      done_q   <= done_d;
      herr_q   <= herr_d;
      verr_q   <= verr_d;
      fcrc_q   <= fcrc_d;
      fcnt_q   <= fcnt_d;
      llen_q   <= llen_d;
      flines_q <= flines_d;
    end
  end

  assign locked_o      = locked_q;
  assign frame_done_o  = done_q;
  assign frame_crc_o   = fcrc_q;
  assign line_len_o    = llen_q;
  assign frame_lines_o = flines_q;
  assign h_err_o       = herr_q;
  assign v_err_o       = verr_q;
  assign frame_cnt_o   = fcnt_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor on a reduced geometry; a frame-level model predicts
// CRC, line counts, error pulses and lock/frame-count behaviour.
module tb_vga_timing_monitor;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 8, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int HLO = HS + HB;
  localparam int VLO = VS + VB;
  localparam logic POL = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic [3:0]  r = '0, g = '0, b = '0;
  logic        hs = 1'b1, vs = 1'b1;
  logic        locked_o, frame_done_o, h_err_o, v_err_o;
  logic [15:0] frame_crc_o, frame_cnt_o;
  logic [11:0] line_len_o;
  logic [10:0] frame_lines_o;
  logic [58:0] outs;

  always #5 clk = ~clk;

  vga_timing_monitor #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(0)
  ) u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pix_en_i     (pix_en),
    .vga_r_i      (r),
    .vga_g_i      (g),
    .vga_b_i      (b),
    .vga_hs_i     (hs),
    .vga_vs_i     (vs),
    .locked_o     (locked_o),
    .frame_done_o (frame_done_o),
    .frame_crc_o  (frame_crc_o),
    .line_len_o   (line_len_o),
    .frame_lines_o(frame_lines_o),
    .h_err_o      (h_err_o),
    .v_err_o      (v_err_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  assign outs = {locked_o, frame_done_o, frame_crc_o, line_len_o, frame_lines_o,
                 h_err_o, v_err_o, frame_cnt_o};

  typedef struct {
    int          lines;
    logic [15:0] crc;
    int          herr;
    int          verr;
    int          last_len;
  } frame_t;

  frame_t      exp_q[$];
  logic [15:0] obs_crc[$];
  int          n_tests = 0, n_fail = 0;
  int          hwin = 0, vwin = 0, ndone = 0, mcnt = 0;
  bit          mlocked = 1'b0, rand_en = 1'b0, good;
  frame_t      mf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bit-serial CRC-16-CCITT (poly 0x1021), MSB first.
  function automatic logic [15:0] crc_px(input logic [15:0] c, input logic [11:0] px);
    logic [15:0] s;
    logic        fb;
    s = c;
    for (int i = 11; i >= 0; i--) begin
      fb = s[15] ^ px[i];
      s  = {s[14:0], 1'b0};
      if (fb) s = s ^ 16'h1021;
    end
    return s;
  endfunction

  task automatic put_px(input logic h, input logic v, input logic [11:0] c);
    if (rand_en) begin
      while ($urandom_range(1, 0) == 0) begin
        @(negedge clk);
        pix_en = 1'b0;
        {r, g, b} = 12'($urandom);
        hs = 1'($urandom);
        vs = 1'($urandom);
      end
    end
    @(negedge clk);
    pix_en = 1'b1;
    hs = h;
    vs = v;
    {r, g, b} = c;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_en = 1'b0;
      {r, g, b} = 12'($urandom);
      hs = 1'($urandom);
      vs = 1'($urandom);
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    pix_en = 1'b0;
    check("pre_rst_locked", locked_o, 1);
    rst = 1'b1;
    #1;
    check("rst_async_outs_zero", outs, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    pix_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("reset_outs_zero", outs, 0);
    rst = 1'b0;
    ndone = 0;
    obs_crc.delete();
  endtask

  // One frame in receiver coordinates: hsync at x=0, vsync at y=0.
  task automatic send_frame(input int nlines, input int vsw, input int bad_line, input int bad_len,
                            input int mode, input bit flip, input int rst_line, input bit push);
    frame_t      f;
    logic [15:0] crc;
    logic [11:0] c;
    int          herr, len, xa, ya;
    bit          act, did_rst;
    crc = 16'hFFFF;
    herr = 0;
    len = HT;
    did_rst = 1'b0;
    for (int y = 0; y < nlines; y++) begin
      len = (y == bad_line) ? bad_len : HT;
      if (len != HT) herr++;
      for (int x = 0; x < len; x++) begin
        xa = x - HLO;
        ya = y - VLO;
        act = (x >= HLO) && (x < HLO + HA) && (y >= VLO) && (y < VLO + VA);
        case (mode)
          0:       c = act ? 12'h000 : 12'($urandom);
          1:       c = act ? {4'(xa), 4'(ya), 4'hA} : 12'($urandom);
          default: c = 12'($urandom);
        endcase
        if (flip && x == HLO + 3 && y == VLO + 2) c = c ^ 12'h100;
        if (act) crc = crc_px(crc, c);
        if (y == rst_line && x == len / 2) begin
          mid_reset();
          did_rst = 1'b1;
        end
        put_px((x < HS) ? POL : ~POL, (y < vsw) ? POL : ~POL, c);
      end
    end
    if (push && !did_rst) begin
      f.lines    = nlines;
      f.crc      = crc;
      f.herr     = herr;
      f.verr     = int'(vsw != VS) + int'(nlines != VT);
      f.last_len = len;
      exp_q.push_back(f);
    end
  endtask

  task automatic good_frame(input int mode);
    send_frame(VT, VS, -1, HT, mode, 1'b0, -1, 1'b1);
  endtask

  task automatic tail();
    send_frame(3, VS, -1, HT, 0, 1'b0, -1, 1'b0);
    idle(4);
    check("frames_pending", exp_q.size(), 0);
  endtask

  // Frame-level monitor and lock model.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      exp_q.delete();
      hwin = 0;
      vwin = 0;
      mlocked = 1'b0;
      mcnt = 0;
    end else begin
      if (h_err_o) hwin++;
      if (v_err_o) vwin++;
      if (h_err_o || v_err_o) begin
        mlocked = 1'b0;
        mcnt = 0;
        check("err_drops_lock", {locked_o, frame_cnt_o}, 0);
      end
      if (frame_done_o) begin
        ndone++;
        obs_crc.push_back(frame_crc_o);
        if (exp_q.size() == 0) begin
          check("unexpected_done", frame_done_o, 0);
        end else begin
          mf = exp_q.pop_front();
          good = (mf.herr == 0) && (mf.verr == 0);
          if (!good) begin
            mlocked = 1'b0;
            mcnt = 0;
          end else if (mlocked) begin
            mcnt = (mcnt + 1) & 16'hFFFF;
          end else begin
            mlocked = 1'b1;
          end
          check("frame_crc", frame_crc_o, mf.crc);
          check("frame_lines", frame_lines_o, mf.lines);
          check("line_len", line_len_o, mf.last_len);
          check("h_err_count", hwin, mf.herr);
          check("v_err_count", vwin, mf.verr);
          check("locked", locked_o, mlocked);
          check("frame_cnt", frame_cnt_o, mcnt);
        end
        hwin = 0;
        vwin = 0;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("initial_reset_outs", outs, 0);
    rst = 1'b0;

    // Nominal stream, constant black, continuous strobe.
    rand_en = 1'b0;
    repeat (3) good_frame(0);
    tail();
    check("s1_done_count", ndone, 3);
    check("s1_locked", locked_o, 1);
    check("s1_frame_cnt", frame_cnt_o, 2);
    check("s1_line_len", line_len_o, HT);
    check("s1_frame_lines", frame_lines_o, VT);

    // Same stream with a ~50% pixel strobe and junk on idle cycles.
    do_reset();
    rand_en = 1'b1;
    repeat (3) good_frame(0);
    tail();
    check("s2_done_count", ndone, 3);
    check("s2_frame_cnt", frame_cnt_o, 2);

    // Short line inside a locked frame, then relock.
    do_reset();
    good_frame(2);
    good_frame(2);
    send_frame(VT, VS, 7, HT - 1, 2, 1'b0, -1, 1'b1);
    good_frame(2);
    good_frame(2);
    tail();
    check("s3_done_count", ndone, 5);
    check("s3_relocked", locked_o, 1);
    check("s3_frame_cnt", frame_cnt_o, 1);

    // Wide vsync, then over-long frames that must not lock.
    do_reset();
    good_frame(2);
    good_frame(2);
    send_frame(VT, VS + 1, -1, HT, 2, 1'b0, -1, 1'b1);
    good_frame(2);
    send_frame(VT + 1, VS, -1, HT, 2, 1'b0, -1, 1'b1);
    send_frame(VT + 1, VS, -1, HT, 2, 1'b0, -1, 1'b1);
    tail();
    check("s4_done_count", ndone, 6);
    check("s4_no_lock", locked_o, 0);
    check("s4_frame_lines", frame_lines_o, VT + 1);

    // Gradient frames; one pixel flipped in the last.
    do_reset();
    rand_en = 1'b0;
    good_frame(1);
    good_frame(1);
    send_frame(VT, VS, -1, HT, 1, 1'b1, -1, 1'b1);
    tail();
    check("s5_done_count", ndone, 3);
    if (obs_crc.size() == 3) check("s5_flip_changes_crc", obs_crc[2] != obs_crc[1], 1);

    // Reset mid-line while locked, then reacquire.
    do_reset();
    rand_en = 1'b1;
    repeat (3) good_frame(2);
    send_frame(VT, VS, -1, HT, 2, 1'b0, VLO + 2, 1'b1);
    good_frame(2);
    good_frame(2);
    tail();
    check("s6_done_count", ndone, 5);
    check("s6_relocked", locked_o, 1);
    check("s6_frame_cnt", frame_cnt_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
